// File: rtl/rr_arbiter_16_encoded_if.sv
// Request/grant bundle between the requesting units and the 16-way arbiter.
// The master side is the requester cluster; the slave side is the arbiter.
interface rr_arbiter_16_encoded_if;
    logic        enable;
    logic [15:0] req;
    logic [15:0] grant;
    logic [3:0]  grant_id;
    logic        grant_valid;
    logic        timeout;

    modport master (
        output enable,
        output req,
        input  grant,
        input  grant_id,
        input  grant_valid,
        input  timeout
    );

    modport slave (
        input  enable,
        input  req,
        output grant,
        output grant_id,
        output grant_valid,
        output timeout
    );
endinterface

// File: rtl/rr_arbiter_16_encoded.sv
// 16-requester round-robin arbiter with a registered one-hot grant, its binary
// index and an optional hold timeout that forces the resource to rotate.
module rr_arbiter_16_encoded #(
    parameter int MAX_HOLD = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    rr_arbiter_16_encoded_if.slave bus
);

    localparam int CNT_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t           state, state_n;
    logic [3:0]       ptr, ptr_n;
    logic [3:0]       grant_id_q, grant_id_n;
    logic [15:0]      grant_q, grant_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             timeout_q, timeout_n;

    logic [31:0]      req_dbl;
    logic [15:0]      req_rot;
    logic [3:0]       offset;
    logic [3:0]       winner;
    logic             rel_req, rel_en, hold_expired;

    // Rotate the request vector so bit 0 is the current priority holder, then
    // take the lowest set bit and rotate the index back.
    always_comb begin
        req_dbl = {bus.req, bus.req} >> ptr;
        req_rot = req_dbl[15:0];
        offset  = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (req_rot[i]) begin
                offset = 4'(i);
            end
        end
        winner = ptr + offset;
    end

    assign rel_req      = ~bus.req[grant_id_q];
    assign rel_en       = ~bus.enable;
    assign hold_expired = (MAX_HOLD != 0) && (cnt == HOLD_LIM);

    always_comb begin
        state_n    = state;
        ptr_n      = ptr;
        cnt_n      = cnt;
        grant_n    = grant_q;
        grant_id_n = grant_id_q;
        timeout_n  = 1'b0;
        case (state)
            IDLE: begin
                grant_n    = 16'd0;
                grant_id_n = 4'd0;
                cnt_n      = '0;
                if (bus.enable && (|bus.req)) begin
                    grant_n    = 16'd1 << winner;
                    grant_id_n = winner;
                    cnt_n      = CNT_W'(1);
                    state_n    = GRANT;
                end
            end
            GRANT: begin
                if (rel_req || rel_en || hold_expired) begin
                    grant_n    = 16'd0;
                    grant_id_n = 4'd0;
                    cnt_n      = '0;
                    ptr_n      = grant_id_q + 4'd1;
                    // Only a pure expiry pulses timeout; a voluntary drop or
                    // disable in the same cycle is not reported as one.
                    timeout_n  = hold_expired && !rel_req && !rel_en;
                    state_n    = IDLE;
                end else if (cnt != CNT_MAX) begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ptr        <= 4'd0;
            cnt        <= '0;
            grant_q    <= 16'd0;
            grant_id_q <= 4'd0;
            timeout_q  <= 1'b0;
        end else begin
            state      <= state_n;
            ptr        <= ptr_n;
            cnt        <= cnt_n;
            grant_q    <= grant_n;
            grant_id_q <= grant_id_n;
            timeout_q  <= timeout_n;
        end
    end

    assign bus.grant       = grant_q;
    assign bus.grant_id    = grant_id_q;
    assign bus.grant_valid = |grant_q;
    assign bus.timeout     = timeout_q;

endmodule

// File: tb/tb_rr_arbiter_16_encoded.sv
// Directed bench for rr_arbiter_16_encoded: one instance with a short hold
// limit and one with the timeout disabled, driven with identical stimulus.
module tb_rr_arbiter_16_encoded;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    rr_arbiter_16_encoded_if a_if ();
    rr_arbiter_16_encoded_if b_if ();

    rr_arbiter_16_encoded #(.MAX_HOLD(4)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (a_if.slave)
    );

    rr_arbiter_16_encoded #(.MAX_HOLD(0)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b_if.slave)
    );

    // Observed outputs packed as {grant, grant_id, grant_valid, timeout}.
    logic [21:0] obs_a;
    logic [21:0] obs_b;
    assign obs_a = {a_if.grant, a_if.grant_id, a_if.grant_valid, a_if.timeout};
    assign obs_b = {b_if.grant, b_if.grant_id, b_if.grant_valid, b_if.timeout};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic en, input logic [15:0] r);
        a_if.enable = en;
        a_if.req    = r;
        b_if.enable = en;
        b_if.req    = r;
    endtask

    task automatic do_reset();
        set_in(1'b0, 16'h0000);
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        set_in(1'b1, 16'hFFFF);
        rst_n = 1'b0;
        repeat (3) step();
        checks++;
        if (obs_a !== 22'd0) begin
            errors++;
            $display("[TB] FAIL reset_a: got %h expected %h", obs_a, 22'd0);
        end
        checks++;
        if (obs_b !== 22'd0) begin
            errors++;
            $display("[TB] FAIL reset_b: got %h expected %h", obs_b, 22'd0);
        end
        set_in(1'b0, 16'h0000);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        do_reset();
        set_in(1'b1, 16'h0001);
        step();
        checks++;
        if (obs_a !== {16'h0001, 4'd0, 1'b1, 1'b0}) begin
            errors++;
            $display("[TB] FAIL basic_grant0: got %h expected %h", obs_a, {16'h0001, 4'd0, 1'b1, 1'b0});
        end
        set_in(1'b1, 16'h0000);
        step();
        checks++;
        if (obs_a !== 22'd0) begin
            errors++;
            $display("[TB] FAIL basic_release: got %h expected %h", obs_a, 22'd0);
        end
        // ptr is now 1, so requester 1 beats requester 0
        set_in(1'b1, 16'h0003);
        step();
        checks++;
        if (obs_a !== {16'h0002, 4'd1, 1'b1, 1'b0}) begin
            errors++;
            $display("[TB] FAIL basic_ptr1: got %h expected %h", obs_a, {16'h0002, 4'd1, 1'b1, 1'b0});
        end
        set_in(1'b1, 16'h0000);
        step();
    endtask

    task automatic test_timeout();
        do_reset();
        set_in(1'b1, 16'h8001);
        for (int c = 0; c < 4; c++) begin
            step();
            checks++;
            if (obs_a !== {16'h0001, 4'd0, 1'b1, 1'b0}) begin
                errors++;
                $display("[TB] FAIL timeout_hold0 cycle %0d: got %h expected %h", c, obs_a, {16'h0001, 4'd0, 1'b1, 1'b0});
            end
        end
        step();
        checks++;
        if (obs_a !== {16'h0000, 4'd0, 1'b0, 1'b1}) begin
            errors++;
            $display("[TB] FAIL timeout_pulse0: got %h expected %h", obs_a, {16'h0000, 4'd0, 1'b0, 1'b1});
        end
        for (int c = 0; c < 4; c++) begin
            step();
            checks++;
            if (obs_a !== {16'h8000, 4'd15, 1'b1, 1'b0}) begin
                errors++;
                $display("[TB] FAIL timeout_hold15 cycle %0d: got %h expected %h", c, obs_a, {16'h8000, 4'd15, 1'b1, 1'b0});
            end
        end
        step();
        checks++;
        if (obs_a !== {16'h0000, 4'd0, 1'b0, 1'b1}) begin
            errors++;
            $display("[TB] FAIL timeout_pulse15: got %h expected %h", obs_a, {16'h0000, 4'd0, 1'b0, 1'b1});
        end
        step();
        checks++;
        if (obs_a !== {16'h0001, 4'd0, 1'b1, 1'b0}) begin
            errors++;
            $display("[TB] FAIL timeout_wrap: got %h expected %h", obs_a, {16'h0001, 4'd0, 1'b1, 1'b0});
        end
        // Voluntary drop must not pulse timeout
        set_in(1'b1, 16'h0000);
        step();
        checks++;
        if (obs_a !== 22'd0) begin
            errors++;
            $display("[TB] FAIL timeout_drop: got %h expected %h", obs_a, 22'd0);
        end
    endtask

    task automatic test_round_robin();
        logic [15:0] exp_grant;
        logic [15:0] r;
        do_reset();
        set_in(1'b1, 16'hFFFF);
        for (int i = 0; i < 17; i++) begin
            step();
            exp_grant = 16'd1 << (i % 16);
            checks++;
            if (obs_a !== {exp_grant, 4'(i % 16), 1'b1, 1'b0}) begin
                errors++;
                $display("[TB] FAIL rr_grant %0d: got %h expected %h", i, obs_a, {exp_grant, 4'(i % 16), 1'b1, 1'b0});
            end
            r = 16'hFFFF & ~exp_grant;
            set_in(1'b1, r);
            step();
            checks++;
            if (obs_a !== 22'd0) begin
                errors++;
                $display("[TB] FAIL rr_idle %0d: got %h expected %h", i, obs_a, 22'd0);
            end
            set_in(1'b1, 16'hFFFF);
        end
        set_in(1'b1, 16'h0000);
        step();
    endtask

    task automatic test_enable();
        do_reset();
        set_in(1'b1, 16'h0060);
        step();
        checks++;
        if (obs_a !== {16'h0020, 4'd5, 1'b1, 1'b0}) begin
            errors++;
            $display("[TB] FAIL en_grant5: got %h expected %h", obs_a, {16'h0020, 4'd5, 1'b1, 1'b0});
        end
        set_in(1'b0, 16'h0060);
        step();
        checks++;
        if (obs_a !== 22'd0) begin
            errors++;
            $display("[TB] FAIL en_revoke: got %h expected %h", obs_a, 22'd0);
        end
        set_in(1'b0, 16'h0020);
        for (int c = 0; c < 2; c++) begin
            step();
            checks++;
            if (obs_a !== 22'd0) begin
                errors++;
                $display("[TB] FAIL en_blocked cycle %0d: got %h expected %h", c, obs_a, 22'd0);
            end
        end
        set_in(1'b1, 16'h0060);
        step();
        checks++;
        if (obs_a !== {16'h0040, 4'd6, 1'b1, 1'b0}) begin
            errors++;
            $display("[TB] FAIL en_regrant6: got %h expected %h", obs_a, {16'h0040, 4'd6, 1'b1, 1'b0});
        end
        set_in(1'b0, 16'h0020);
        step();
        set_in(1'b1, 16'h0020);
        step();
        checks++;
        if (obs_a !== {16'h0020, 4'd5, 1'b1, 1'b0}) begin
            errors++;
            $display("[TB] FAIL en_regrant5: got %h expected %h", obs_a, {16'h0020, 4'd5, 1'b1, 1'b0});
        end
        set_in(1'b1, 16'h0000);
        step();
    endtask

    task automatic test_async_reset();
        do_reset();
        // Serve requester 3 once so ptr moves to 4, then grant it again
        set_in(1'b1, 16'h0008);
        step();
        set_in(1'b1, 16'h0000);
        step();
        set_in(1'b1, 16'h0008);
        step();
        checks++;
        if (obs_a !== {16'h0008, 4'd3, 1'b1, 1'b0}) begin
            errors++;
            $display("[TB] FAIL arst_pre: got %h expected %h", obs_a, {16'h0008, 4'd3, 1'b1, 1'b0});
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs_a !== 22'd0) begin
            errors++;
            $display("[TB] FAIL arst_clear: got %h expected %h", obs_a, 22'd0);
        end
        set_in(1'b1, 16'h0018);
        step();
        #4;
        rst_n = 1'b1;
        step();
        checks++;
        if (obs_a !== {16'h0008, 4'd3, 1'b1, 1'b0}) begin
            errors++;
            $display("[TB] FAIL arst_ptr0: got %h expected %h", obs_a, {16'h0008, 4'd3, 1'b1, 1'b0});
        end
        set_in(1'b1, 16'h0000);
        step();
    endtask

    task automatic test_no_timeout();
        int bad;
        bad = 0;
        do_reset();
        set_in(1'b1, 16'h0400);
        for (int c = 0; c < 200; c++) begin
            step();
            checks++;
            if (obs_b !== {16'h0400, 4'd10, 1'b1, 1'b0}) begin
                errors++;
                if (bad < 5) begin
                    $display("[TB] FAIL nohold cycle %0d: got %h expected %h", c, obs_b, {16'h0400, 4'd10, 1'b1, 1'b0});
                end
                bad++;
            end
        end
        set_in(1'b1, 16'h0000);
        step();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        set_in(1'b0, 16'h0000);
        $display("[TB] starting rr_arbiter_16_encoded bench");
        test_reset();
        test_basic();
        test_timeout();
        test_round_robin();
        test_enable();
        test_async_reset();
        test_no_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
